// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the audio moving-average filter
package audio_pkg;

   localparam int AUDIO_W      = 24;
   localparam int MAX_LOG2_N   = 8;
   localparam int MAX_CHANNELS = 8;

   typedef logic signed [AUDIO_W-1:0] sample_t;

   // Extract channel c from a packed frame; channel c sits at [c*AUDIO_W +: AUDIO_W].
   function automatic sample_t ch_slice(input logic [MAX_CHANNELS*AUDIO_W-1:0] bus,
                                        input int c);
      return bus[c*AUDIO_W +: AUDIO_W];
   endfunction

endpackage

// File: rtl/sample_ring.sv
// rtl/sample_ring.sv - per-channel N-entry history ring with combinational read
module sample_ring
   import audio_pkg::*;
#(
   parameter int DATA_W = AUDIO_W,
   parameter int LOG2_N = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [LOG2_N-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int N = 1 << LOG2_N;

   // No reset on the storage: the parent's fill level masks stale entries.
   logic [DATA_W-1:0] mem [0:N-1];

   // Read and write share one address: the slot about to be overwritten is the oldest sample.
   assign rdata = mem[addr];

   // Store the new scaled sample in place of the oldest one.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/audio_avg_filter.sv
// rtl/audio_avg_filter.sv - multi-channel N-tap boxcar filter between codec read and write sides
//
// Codec hook-up in the enclosing design:
//   in_valid = read_ready, read = in_valid & in_ready,
//   in_data  = {readdata_right, readdata_left},
//   write    = out_valid & write_ready, out_ready = write_ready.
module audio_avg_filter
   import audio_pkg::*;
#(
   parameter int DATA_W   = AUDIO_W,
   parameter int LOG2_N   = 3,
   parameter int CHANNELS = 2
) (
   input  logic                       CLOCK_50,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       bypass,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CHANNELS*DATA_W-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CHANNELS*DATA_W-1:0] out_data,
   output logic [LOG2_N:0]            fill_level
);

   localparam int             N        = 1 << LOG2_N;
   localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N+1)'(N);

   logic              in_fire;
   logic              out_fire;
   logic              hist_upd;
   logic              hist_full;
   logic [LOG2_N-1:0] wr_ptr;

   // Next output frame, assembled channel by channel below.
   wire  [CHANNELS*DATA_W-1:0] frame_nxt;

   // A single output register stage: accept whenever it is empty or draining this cycle.
   assign in_ready  = !out_valid | out_ready;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   // Clear outranks a simultaneous frame, which is then dropped.
   assign hist_upd  = in_fire & !clear;
   assign hist_full = (fill_level == FILL_MAX);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [DATA_W-1:0] in_ch;
      logic signed [DATA_W-1:0] scaled;
      logic signed [DATA_W-1:0] ring_rd;
      logic signed [DATA_W-1:0] oldest;
      logic signed [DATA_W-1:0] acc_q;
      logic signed [DATA_W-1:0] acc_nxt;

      assign in_ch  = in_data[c*DATA_W +: DATA_W];
      // Pre-scaling each sample keeps the running sum inside DATA_W bits.
      assign scaled = in_ch >>> LOG2_N;
      // Until the window is full, the slot being overwritten holds no live sample.
      assign oldest = hist_full ? ring_rd : '0;
      assign acc_nxt = acc_q + scaled - oldest;

      assign frame_nxt[c*DATA_W +: DATA_W] = bypass ? in_ch : acc_nxt;

      sample_ring #(
         .DATA_W (DATA_W),
         .LOG2_N (LOG2_N)
      ) u_ring (
         .clk   (CLOCK_50),
         .we    (hist_upd),
         .addr  (wr_ptr),
         .wdata (scaled),
         .rdata (ring_rd)
      );

      // Running window sum; keeps tracking in bypass so leaving bypass is seamless.
      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
         if (!reset_n) begin
            acc_q <= '0;
         end else if (clear) begin
            acc_q <= '0;
         end else if (in_fire) begin
            acc_q <= acc_nxt;
         end
      end
   end

   // Shared write pointer and saturating fill count for all channels.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         fill_level <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         fill_level <= '0;
      end else if (in_fire) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (!hist_full) begin
            fill_level <= fill_level + 1'b1;
         end
      end
   end

   // Output register: loads on an accepted frame, holds under backpressure; clear leaves it alone.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (hist_upd) begin
         out_valid <= 1'b1;
         out_data  <= frame_nxt;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

endmodule
